fetch_sequencer: RTL

Instruction-fetch controller for the 32-bit single-cycle RISC-V core. It owns the architectural PC, runs a single-outstanding-request handshake to instruction memory, and presents each fetched word to decode with a valid/ready handshake. Branch/jump redirects, traps and halt requests from execute are applied here, so no wrong-path word ever reaches decode.

---
 rtl/fetch_sequencer_pkg.sv | 21 ++
 rtl/fetch_redirect_latch.sv | 60 ++++++
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch definitions: FSM state encodings, NOP word, default vectors.
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        FS_BOOT = 3'd0,
        FS_REQ  = 3'd1,
        FS_WAIT = 3'd2,
        FS_HOLD = 3'd3,
        FS_HALT = 3'd4
    } fs_state_e;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

    // Instruction fetch addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_redirect_latch.sv
// Redirect bookkeeping for the fetch FSM: picks trap over branch redirect,
// remembers a redirect that arrived while a request was in flight (kill +
// pend_target, latest wins) and latches halt requests until a boundary.
module fetch_redirect_latch
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    input  logic        halt_i,
    input  logic        arm_i,        // request outstanding or being issued
    input  logic        discard_i,    // in-flight response is being thrown away
    input  logic        halt_ack_i,   // FSM is entering HALT this cycle
    output logic        take_o,
    output logic [31:0] target_o,
    output logic        kill_o,
    output logic [31:0] pend_target_o,
    output logic        halt_req_o
);

    logic        kill_q;
    logic [31:0] pend_q;
    logic        hpend_q;

    // Priority select of the redirect source; trap always wins.
    always_comb begin
        take_o   = trap_i | redirect_valid_i;
        target_o = trap_i ? TRAP_VECTOR : word_align(redirect_target_i);
    end

    // A discard consumes the kill; otherwise a redirect during REQ/WAIT arms it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kill_q  <= 1'b0;
            pend_q  <= DEF_RESET_VECTOR;
            hpend_q <= 1'b0;
        end else begin
            if (discard_i) begin
                kill_q <= 1'b0;
            end else if (arm_i && take_o) begin
                kill_q <= 1'b1;
                pend_q <= target_o;
            end
            if (halt_ack_i)
                hpend_q <= 1'b0;
            else if (halt_i)
                hpend_q <= 1'b1;
        end
    end

    assign kill_o        = kill_q;
    assign pend_target_o = pend_q;
    // A halt arriving on the boundary cycle itself is honoured immediately.
    assign halt_req_o    = hpend_q | halt_i;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one outstanding imem
// request at a time and hands fetched words to decode. Wrong-path responses
// are dropped here so decode only ever sees correct-path instructions.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        pipe_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap,
    input  logic        halt,
    output logic        halted
);

    fs_state_e   state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;

    logic        take;
    logic [31:0] target;
    logic        kill;
    logic [31:0] pend_target;
    logic        halt_req;
    logic        discard;
    logic        hold_accept;
    logic        go_halt;

    // Boundary events that the redirect latch must know about.
    always_comb begin
        discard     = (state_q == FS_WAIT) && imem_rvalid && (kill || take);
        hold_accept = (state_q == FS_HOLD) && !take && pipe_ready;
        go_halt     = (discard || hold_accept) && halt_req && !take;
    end

    fetch_redirect_latch #(
        .TRAP_VECTOR(TRAP_VECTOR)
    ) u_redir (
        .clk              (clk),
        .rst              (rst),
        .trap_i           (trap),
        .redirect_valid_i (redirect_valid),
        .redirect_target_i(redirect_target),
        .halt_i           (halt),
        .arm_i            ((state_q == FS_REQ) || (state_q == FS_WAIT)),
        .discard_i        (discard),
        .halt_ack_i       (go_halt),
        .take_o           (take),
        .target_o         (target),
        .kill_o           (kill),
        .pend_target_o    (pend_target),
        .halt_req_o       (halt_req)
    );

    // Fetch FSM, PC and the instruction/PC pair presented to decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FS_BOOT;
            pc_q       <= RESET_VECTOR;
            instr_q    <= NOP_INSN;
            instr_pc_q <= RESET_VECTOR;
        end else begin
            case (state_q)
                FS_BOOT: begin
                    if (take)
                        pc_q <= target;
                    state_q <= FS_REQ;
                end
                FS_REQ: begin
                    if (imem_gnt)
                        state_q <= FS_WAIT;
                end
                FS_WAIT: begin
                    if (discard) begin
                        pc_q    <= take ? target : pend_target;
                        state_q <= go_halt ? FS_HALT : FS_REQ;
                    end else if (imem_rvalid) begin
                        instr_q    <= imem_rdata;
                        instr_pc_q <= pc_q;
                        state_q    <= FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    if (take) begin
                        pc_q    <= target;
                        state_q <= FS_REQ;
                    end else if (pipe_ready) begin
                        pc_q    <= pc_q + 32'd4;
                        state_q <= go_halt ? FS_HALT : FS_REQ;
                    end
                end
                FS_HALT: begin
                    if (take) begin
                        pc_q    <= target;
                        state_q <= FS_REQ;
                    end
                end
                default: state_q <= FS_BOOT;
            endcase
        end
    end

    assign imem_req    = (state_q == FS_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == FS_HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = (state_q == FS_HALT);

endmodule
